restoring_divider: RTL
======================

Name: restoring_divider

Overview:
Sequential unsigned integer divider for the Mini_ALU. It is the multi-cycle counterpart to the combinational add/subtract datapath: it performs division by repeated trial subtraction, one quotient bit per clock. It sits beside the adder/subtractor behind the ALU operation select and uses a start/done handshake toward the ALU control.

Parameters:
WIDTH, 6, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a division; sampled only while idle
dividend  input  WIDTH  unsigned dividend, captured with an accepted start
divisor  input  WIDTH  unsigned divisor, captured with an accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse, results valid from this cycle onward
quotient  output  WIDTH  unsigned quotient, held until next completion
remainder  output  WIDTH  unsigned remainder, held until next completion
div_by_zero  output  1  high with done when the captured divisor was 0; held with results

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, step counter=0. Reset mid-division aborts it; no done is produced.
- FSM states: IDLE, CALC. There is no separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge k: capture dividend/divisor. Clear partial remainder (WIDTH+1 bits). Load dividend into quotient shift register. Clear step counter.
  - Divisor != 0: go to CALC, busy=1.
  - Divisor == 0: stay IDLE. At edge k set quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, done=1. Latency is 1 cycle.
- CALC, each edge performs one iteration:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial value = shifted partial remainder minus {0,divisor}, computed at WIDTH+1 bits.
  - Trial MSB=0: partial remainder = trial value, new quotient LSB = 1.
  - Trial MSB=1: keep shifted remainder (restore), new quotient LSB = 0.
  - Counter increments each step.
- The iteration with counter==WIDTH-1 is the last: at edge k+WIDTH the final quotient/remainder (low WIDTH bits) go to the outputs, div_by_zero=0, done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after start was accepted.
- done is high for exactly one cycle and otherwise 0.
- start while busy=1: ignored. No queuing, no effect on the operation in progress.
- start=1 in the cycle where done=1: accepted (state is IDLE), so back-to-back operations are allowed. Outputs keep the previous result until the new one completes.
- Output registers change only on completion or reset. They do not change during CALC.
- Invariant on normal completion: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package alu_pkg:
  - DIV_WIDTH default constant (6)
  - state enum {IDLE, CALC}
  - counter width constant $clog2(WIDTH)
- Sub-module div_step (combinational):
  - inputs: partial remainder (WIDTH+1), incoming dividend bit, divisor
  - outputs: next partial remainder, quotient bit
  - It holds the trial subtract/restore, so the top-level module contains only the FSM, counter and registers.

Test Plan:
- dividend=45, divisor=7, start one cycle → busy for 6 cycles, done pulse 6 cycles after acceptance, quotient=6, remainder=3, div_by_zero=0.
- dividend=63, divisor=1 → quotient=63, remainder=0. Then dividend=5, divisor=9 → quotient=0, remainder=5. Issue the second start in the done cycle of the first to check back-to-back acceptance.
- dividend=13, divisor=0 → done on the next cycle, quotient=63, remainder=13, div_by_zero=1, busy never asserted.
- Start 45/7, then pulse start with 20/4 two cycles later → second start ignored; result 6/3 at the original time, done pulses once.
- Start 45/7, drive reset_n=0 at edge k+3 → busy=0, all outputs 0, no done afterwards. Then 20/4 completes with quotient=5, remainder=0.
- Exhaustive sweep of all 64×64 operand pairs with self-check: q*d+r==dividend and r<d for d!=0, plus the divide-by-zero rule for d=0; done width always 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the Mini_ALU datapath blocks.
package alu_pkg;

    localparam int unsigned DIV_WIDTH = 6;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

    // Step counter width for an arbitrary divider width (WIDTH >= 2).
    function automatic int unsigned div_cnt_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           rem_msb_unused;

    // The partial remainder is always below the divisor, so its MSB is zero on entry.
    assign rem_msb_unused = rem_in[WIDTH];
    assign shifted        = {rem_in[WIDTH-1:0], bit_in};
    assign trial          = shifted - {1'b0, divisor};

    always_comb begin
        rem_out = shifted;
        q_bit   = 1'b0;
        if (!trial[WIDTH]) begin
            rem_out = trial;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
module restoring_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = div_cnt_width(WIDTH);

    div_state_t       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] next_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (qreg[WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign next_q = {qreg[WIDTH-2:0], step_q};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            qreg        <= '0;
            dsr         <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dsr  <= divisor;
                        rem  <= '0;
                        qreg <= dividend;
                        cnt  <= '0;
                        if (divisor != '0) begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end else begin
                            // Divide by zero completes immediately with an all-ones quotient.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem  <= step_rem;
                    qreg <= next_q;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= next_q;
                        remainder   <= step_rem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
